// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and requester identifiers for the RegFile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the requester favoured on contention
// and moves to the other requester after every grant.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (en && Resetn) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_ptr == REQ_ALU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rr_ptr <= REQ_ALU;
    end else if (gnt[0]) begin
      rr_ptr <= REQ_MEM;
    end else if (gnt[1]) begin
      rr_ptr <= REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between ALU and load writeback, with a registered
// issue stage and forwarding of the in-flight write to the two read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Hold,
  input  logic              Req0_v,
  input  logic [ADDR_W-1:0] Req0_wn,
  input  logic [DATA_W-1:0] Req0_wd,
  output logic              Req0_rdy,
  input  logic              Req1_v,
  input  logic [ADDR_W-1:0] Req1_wn,
  input  logic [DATA_W-1:0] Req1_wd,
  output logic              Req1_rdy,
  output logic [ADDR_W-1:0] Wn,
  output logic [DATA_W-1:0] Wd,
  output logic              Write,
  input  logic [ADDR_W-1:0] Rn1,
  input  logic [ADDR_W-1:0] Rn2,
  output logic              Fwd1,
  output logic              Fwd2,
  output logic [DATA_W-1:0] FwdD
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [1:0]        gnt;
  logic              accept;
  logic [ADDR_W-1:0] sel_wn;
  logic [DATA_W-1:0] sel_wd;

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (~Hold),
    .req    ({Req1_v, Req0_v}),
    .gnt    (gnt)
  );

  assign Req0_rdy = gnt[0];
  assign Req1_rdy = gnt[1];

  always_comb begin
    accept = |gnt;
    sel_wn = Req0_wn;
    sel_wd = Req0_wd;
    if (gnt[1]) begin
      sel_wn = Req1_wn;
      sel_wd = Req1_wd;
    end
  end

  // Issue stage: register 0 is accepted but never raises Write.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Wn    <= '0;
      Wd    <= '0;
      Write <= 1'b0;
    end else begin
      Write <= accept && (sel_wn != ZERO_IDX);
      if (accept) begin
        Wn <= sel_wn;
        Wd <= sel_wd;
      end
    end
  end

  assign Fwd1 = Write && (Rn1 == Wn) && (Rn1 != ZERO_IDX);
  assign Fwd2 = Write && (Rn2 == Wn) && (Rn2 != ZERO_IDX);
  assign FwdD = Wd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios plus random traffic.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clock;
  logic          Resetn;
  logic          Hold;
  logic          Req0_v, Req1_v;
  logic [AW-1:0] Req0_wn, Req1_wn;
  logic [DW-1:0] Req0_wd, Req1_wd;
  logic          Req0_rdy, Req1_rdy;
  logic [AW-1:0] Wn;
  logic [DW-1:0] Wd;
  logic          Write;
  logic [AW-1:0] Rn1, Rn2;
  logic          Fwd1, Fwd2;
  logic [DW-1:0] FwdD;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Hold(Hold),
    .Req0_v(Req0_v), .Req0_wn(Req0_wn), .Req0_wd(Req0_wd), .Req0_rdy(Req0_rdy),
    .Req1_v(Req1_v), .Req1_wn(Req1_wn), .Req1_wd(Req1_wd), .Req1_rdy(Req1_rdy),
    .Wn(Wn), .Wd(Wd), .Write(Write),
    .Rn1(Rn1), .Rn2(Rn2), .Fwd1(Fwd1), .Fwd2(Fwd2), .FwdD(FwdD)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] rf[32];
  logic [DW-1:0] exp_rf[32];
  int            n_chk = 0;
  int            n_fail = 0;
  int            fav = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment RegFile fed by the DUT write port.
  always @(posedge Clock) begin
    if (Write) rf[Wn] <= Wd;
  end

  // Monitor: every accepted nonzero write must issue exactly one cycle later.
  wr_t mon_e;
  bit  mon_ew;
  always @(negedge Clock) begin
    if (Resetn) begin
      mon_ew = exp_q.size() > 0;
      chk("write", 32'(Write), 32'(mon_ew));
      if (mon_ew) begin
        mon_e = exp_q.pop_front();
        chk("wn", 32'(Wn), 32'(mon_e.wn));
        chk("wd", Wd, mon_e.wd);
        chk("fwdd", FwdD, mon_e.wd);
        exp_rf[mon_e.wn] = mon_e.wd;
      end
      chk("fwd1", 32'(Fwd1), 32'(mon_ew && Rn1 == mon_e.wn && Rn1 != 0));
      chk("fwd2", 32'(Fwd2), 32'(mon_ew && Rn2 == mon_e.wn && Rn2 != 0));
    end
  end

  // Drive one cycle of inputs, predict and check the grant, queue the expected write.
  task automatic cycle(bit h, bit v0, logic [AW-1:0] wn0, logic [DW-1:0] wd0,
                       bit v1, logic [AW-1:0] wn1, logic [DW-1:0] wd1,
                       logic [AW-1:0] r1, logic [AW-1:0] r2);
    int  win;
    bit  push;
    wr_t p;
    Hold = h; Req0_v = v0; Req0_wn = wn0; Req0_wd = wd0;
    Req1_v = v1; Req1_wn = wn1; Req1_wd = wd1; Rn1 = r1; Rn2 = r2;
    @(negedge Clock);
    win = -1;
    if (!h) begin
      if (v0 && v1) win = fav;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    chk("rdy0", 32'(Req0_rdy), 32'(win == 0));
    chk("rdy1", 32'(Req1_rdy), 32'(win == 1));
    push = 1'b0;
    if (win >= 0) begin
      fav  = 1 - win;
      p.wn = (win == 1) ? wn1 : wn0;
      p.wd = (win == 1) ? wd1 : wd0;
      push = (p.wn != 0);
    end
    @(posedge Clock);
    if (push) exp_q.push_back(p);
    #1;
  endtask

  task automatic idle(logic [AW-1:0] r1, logic [AW-1:0] r2);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  initial begin
    int first;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      exp_rf[i] = '0;
    end
    Resetn = 1'b0; Hold = 1'b0;
    Req0_v = 1'b1; Req0_wn = 5'd2; Req0_wd = 32'h11;
    Req1_v = 1'b1; Req1_wn = 5'd4; Req1_wd = 32'h22;
    Rn1 = 5'd0; Rn2 = 5'd0;
    repeat (2) @(negedge Clock);
    chk("rst_rdy0", 32'(Req0_rdy), 32'd0);
    chk("rst_rdy1", 32'(Req1_rdy), 32'd0);
    chk("rst_write", 32'(Write), 32'd0);
    chk("rst_wn", 32'(Wn), 32'd0);
    chk("rst_wd", Wd, 32'd0);
    chk("rst_fwd", 32'({Fwd1, Fwd2}), 32'd0);
    @(posedge Clock); #1;
    Resetn = 1'b1;

    cycle(1'b0, 1'b1, 5'd2, 32'h11, 1'b1, 5'd4, 32'h22, 5'd2, 5'd4);
    cycle(1'b0, 1'b1, 5'd1, 32'd1023, 1'b0, '0, '0, 5'd1, 5'd0);
    idle(5'd1, 5'd1);
    idle(5'd1, 5'd0);
    chk("rf1_readback", rf[1], 32'd1023);

    repeat (4) cycle(1'b0, 1'b1, 5'd3, 32'd2047, 1'b1, 5'd5, 32'd7, 5'd3, 5'd5);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hdead, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    first = fav;
    cycle(1'b0, 1'b1, 5'd3, 32'd10, 1'b1, 5'd3, 32'd20, 5'd1, 5'd3);
    if (first == 0) cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'd20, 5'd1, 5'd3);
    else            cycle(1'b0, 1'b1, 5'd3, 32'd10, 1'b0, '0, '0, 5'd1, 5'd3);
    idle(5'd3, 5'd3);
    idle(5'd0, 5'd0);
    chk("same_dest_reg3", rf[3], (first == 0) ? 32'd20 : 32'd10);

    repeat (3) cycle(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd7, 5'd8);
    cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd7, 5'd8);
    idle(5'd0, 5'd0);

    cycle(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 5'd6, 5'd6);
    chk("pre_rst_write", 32'(Write), 32'd1);
    #1 Resetn = 1'b0;
    #1;
    chk("mid_rst_write", 32'(Write), 32'd0);
    chk("mid_rst_rdy0", 32'(Req0_rdy), 32'd0);
    chk("mid_rst_fwd1", 32'(Fwd1), 32'd0);
    exp_q.delete();
    fav = 0;
    @(posedge Clock); #1;
    Resetn = 1'b1;

    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rf_%0d", i), rf[i], exp_rf[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
